// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM host arbiter: target-select encoding,
// host-count limit and the address decoder used at grant time.
package sram_arb_pkg;

    localparam int MaxHosts = 8;
    localparam int HostIdxW = 3;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_MEM  = 2'd1,
        TGT_GPIO = 2'd2,
        TGT_ERR  = 2'd3
    } tgt_e;

    // SRAM window wins over the GPIO word if the two ever overlap.
    function automatic tgt_e decode_target(
        input logic [31:0] addr,
        input logic [31:0] mem_start,
        input logic [31:0] mem_size,
        input logic [31:0] gpio_addr
    );
        if ((addr & ~(mem_size - 32'd1)) == mem_start) begin
            return TGT_MEM;
        end else if (addr[31:2] == gpio_addr[31:2]) begin
            return TGT_GPIO;
        end else begin
            return TGT_ERR;
        end
    endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Grant selector: one-hot grant from a request vector. Round-robin with an
// internal pointer when SRAM_ARB_RR_EN is defined, fixed lowest-index priority otherwise.
module sram_arb_rr
    import sram_arb_pkg::*;
#(
    parameter int NumHosts = 2
) (
    input  logic                clk_sys,
    input  logic                rst_sys_n,
    input  logic [NumHosts-1:0] req,
    output logic [NumHosts-1:0] gnt,
    output logic [HostIdxW-1:0] winner,
    output logic                any_gnt
);

`ifdef SRAM_ARB_RR_EN
    logic [HostIdxW-1:0] ptr;
    int                  idx;

    // Scan starts at the pointer and wraps, so the last winner is visited last.
    always_comb begin
        gnt     = '0;
        winner  = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int k = 0; k < NumHosts; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NumHosts) begin
                idx = idx - NumHosts;
            end
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = HostIdxW'(idx);
                any_gnt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (int'(winner) == NumHosts - 1) ? '0 : winner + 1'b1;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_sys ^ rst_sys_n;

    always_comb begin
        gnt     = '0;
        winner  = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NumHosts; k++) begin
            if (!any_gnt && req[k]) begin
                gnt[k]  = 1'b1;
                winner  = HostIdxW'(k);
                any_gnt = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sram_host_arbiter.sv
// Multi-host arbiter in front of a single-port SRAM plus one GPIO output word.
// Arbitration policy is round-robin when SRAM_ARB_RR_EN is defined, fixed priority otherwise.
module sram_host_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          NumHosts  = 2,
    parameter logic [31:0] MemStart  = 32'h0000_0000,
    parameter int          MemSize   = 65536,
    parameter logic [31:0] GpioAddr  = 32'h8000_0000,
    parameter int          GpioWidth = 8
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys_n,
    input  logic [NumHosts-1:0]       host_req_i,
    input  logic [NumHosts-1:0]       host_we_i,
    input  logic [NumHosts-1:0][31:0] host_addr_i,
    input  logic [NumHosts-1:0][31:0] host_wdata_i,
    input  logic [NumHosts-1:0][3:0]  host_be_i,
    output logic [NumHosts-1:0]       host_gnt_o,
    output logic [NumHosts-1:0]       host_rvalid_o,
    output logic [NumHosts-1:0]       host_err_o,
    output logic [NumHosts-1:0][31:0] host_rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i,
    output logic [GpioWidth-1:0]      gpio_o
);

    logic [NumHosts-1:0]  gnt;
    logic [HostIdxW-1:0]  winner;
    logic                 any_gnt;
    logic                 sel_we;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_be;
    tgt_e                 tgt_p0;
    logic [GpioWidth-1:0] gpio_q;
    logic [GpioWidth-1:0] gpio_nxt;
    logic [HostIdxW-1:0]  owner_idx_p1;
    tgt_e                 owner_tgt_p1;
    logic [31:0]          resp_data;

    sram_arb_rr #(
        .NumHosts (NumHosts)
    ) u_arb (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .req       (host_req_i),
        .gnt       (gnt),
        .winner    (winner),
        .any_gnt   (any_gnt)
    );

    assign host_gnt_o = gnt;

    // Stage p0: steer the granted host's request and decode its target.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int h = 0; h < NumHosts; h++) begin
            if (gnt[h]) begin
                sel_we    = host_we_i[h];
                sel_addr  = host_addr_i[h];
                sel_wdata = host_wdata_i[h];
                sel_be    = host_be_i[h];
            end
        end
    end

    assign tgt_p0 = any_gnt ? decode_target(sel_addr, MemStart, 32'(MemSize), GpioAddr)
                            : TGT_NONE;

    assign mem_req_o   = (tgt_p0 == TGT_MEM);
    assign mem_we_o    = mem_req_o & sel_we;
    assign mem_be_o    = mem_req_o ? sel_be    : 4'd0;
    assign mem_addr_o  = mem_req_o ? sel_addr  : 32'd0;
    assign mem_wdata_o = mem_req_o ? sel_wdata : 32'd0;

    // Lanes above GpioWidth have no storage, so their enables simply fall away.
    always_comb begin
        gpio_nxt = gpio_q;
        for (int i = 0; i < GpioWidth; i++) begin
            if (sel_be[i / 8]) begin
                gpio_nxt[i] = sel_wdata[i];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            gpio_q <= '0;
        end else if (tgt_p0 == TGT_GPIO && sel_we) begin
            gpio_q <= gpio_nxt;
        end
    end

    assign gpio_o = gpio_q;

    // Stage p1: response owner captured at grant time.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            owner_idx_p1 <= '0;
            owner_tgt_p1 <= TGT_NONE;
        end else begin
            owner_idx_p1 <= winner;
            owner_tgt_p1 <= tgt_p0;
        end
    end

    // GPIO data comes from the register as it stands during the response cycle,
    // which is still the pre-write value if a write was granted this same cycle.
    always_comb begin
        case (owner_tgt_p1)
            TGT_MEM:  resp_data = mem_rdata_i;
            TGT_GPIO: resp_data = 32'(gpio_q);
            default:  resp_data = 32'd0;
        endcase
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < NumHosts; h++) begin
            host_rdata_o[h] = resp_data;
            if (owner_tgt_p1 != TGT_NONE && int'(owner_idx_p1) == h) begin
                host_rvalid_o[h] = 1'b1;
                host_err_o[h]    = (owner_tgt_p1 == TGT_ERR);
            end
        end
    end

endmodule

// File: tb/tb_sram_host_arbiter.sv
// Bench for sram_host_arbiter (3 hosts): transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_sram_host_arbiter;

    localparam int          NH        = 3;
    localparam int          GW        = 8;
    localparam logic [31:0] MEM_START = 32'h0000_0000;
    localparam int          MEM_SIZE  = 65536;
    localparam logic [31:0] GPIO_ADDR = 32'h8000_0000;

    logic                clk_sys   = 1'b0;
    logic                rst_sys_n = 1'b0;
    logic [NH-1:0]       host_req_i;
    logic [NH-1:0]       host_we_i;
    logic [NH-1:0][31:0] host_addr_i;
    logic [NH-1:0][31:0] host_wdata_i;
    logic [NH-1:0][3:0]  host_be_i;
    logic [NH-1:0]       host_gnt_o;
    logic [NH-1:0]       host_rvalid_o;
    logic [NH-1:0]       host_err_o;
    logic [NH-1:0][31:0] host_rdata_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [3:0]          mem_be_o;
    logic [31:0]         mem_addr_o;
    logic [31:0]         mem_wdata_o;
    logic [31:0]         mem_rdata_i;
    logic [GW-1:0]       gpio_o;

    always #5 clk_sys = ~clk_sys;

    sram_host_arbiter #(
        .NumHosts  (NH),
        .MemStart  (MEM_START),
        .MemSize   (MEM_SIZE),
        .GpioAddr  (GPIO_ADDR),
        .GpioWidth (GW)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_sys_n     (rst_sys_n),
        .host_req_i    (host_req_i),
        .host_we_i     (host_we_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_be_i     (host_be_i),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_err_o    (host_err_o),
        .host_rdata_o  (host_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .gpio_o        (gpio_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // SRAM behaviour: word-addressed store, read data one cycle after the request.
    logic [31:0] smem [int];
    logic [31:0] sram_word;

    function automatic logic [31:0] smem_rd(input int w);
        return smem.exists(w) ? smem[w] : 32'h0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    always @(posedge clk_sys) begin
        if (mem_req_o) begin
            sram_word = smem_rd(int'(mem_addr_o[31:2]));
            if (mem_we_o) begin
                smem[int'(mem_addr_o[31:2])] = (sram_word & ~lane_mask(mem_be_o))
                                             | (mem_wdata_o & lane_mask(mem_be_o));
            end
            mem_rdata_i <= sram_word;
        end
    end

    // Transaction model: pending response, GPIO contents, arbitration pointer.
    int            m_ptr  = 0;
    logic [GW-1:0] m_gpio = '0;
    int            m_kind = 0;   // 0 none, 1 sram, 2 gpio, 3 unmapped
    int            m_idx  = 0;
    logic          m_we   = 1'b0;
    logic [31:0]   m_data = '0;
    int            grant_q[$];
    bit            mem_req_seen = 1'b0;

    int            w;
    int            kind;
    logic [31:0]   a;
    logic [31:0]   nxt;
    logic [NH-1:0] e_rv, e_err, e_gnt;

    always @(negedge clk_sys) begin
        if (mem_req_o) mem_req_seen = 1'b1;
        if (!rst_sys_n) begin
            chk("rst_rvalid", 32'(host_rvalid_o), 32'd0);
            chk("rst_err", 32'(host_err_o), 32'd0);
            chk("rst_gpio", 32'(gpio_o), 32'd0);
            m_kind = 0;
            m_gpio = '0;
            m_ptr  = 0;
        end else begin
            e_rv  = '0;
            e_err = '0;
            if (m_kind != 0) begin
                e_rv[m_idx]  = 1'b1;
                e_err[m_idx] = (m_kind == 3);
            end
            chk("rvalid", 32'(host_rvalid_o), 32'(e_rv));
            chk("err", 32'(host_err_o), 32'(e_err));
            if (m_kind != 0 && !m_we) begin
                chk("rdata", host_rdata_o[m_idx],
                    (m_kind == 1) ? m_data : (m_kind == 2) ? 32'(m_gpio) : 32'd0);
            end
            chk("gpio", 32'(gpio_o), 32'(m_gpio));

            w = -1;
`ifdef SRAM_ARB_RR_EN
            for (int k = 0; k < NH; k++) begin
                if (w < 0 && host_req_i[(m_ptr + k) % NH]) w = (m_ptr + k) % NH;
            end
`else
            for (int h = 0; h < NH; h++) begin
                if (w < 0 && host_req_i[h]) w = h;
            end
`endif
            e_gnt = '0;
            if (w >= 0) e_gnt[w] = 1'b1;
            chk("gnt", 32'(host_gnt_o), 32'(e_gnt));

            kind = 0;
            a    = '0;
            if (w >= 0) begin
                a = host_addr_i[w];
                if (a >= MEM_START && (a - MEM_START) < 32'(MEM_SIZE)) kind = 1;
                else if ((a >> 2) == (GPIO_ADDR >> 2))                 kind = 2;
                else                                                   kind = 3;
            end
            chk("mem_req", 32'(mem_req_o), 32'(kind == 1));
            if (kind == 1) begin
                chk("mem_addr", mem_addr_o, a);
                chk("mem_we", 32'(mem_we_o), 32'(host_we_i[w]));
                chk("mem_be", 32'(mem_be_o), 32'(host_be_i[w]));
                if (host_we_i[w]) chk("mem_wdata", mem_wdata_o, host_wdata_i[w]);
            end else begin
                chk("mem_idle", mem_addr_o | mem_wdata_o | 32'(mem_be_o) | 32'(mem_we_o), 32'd0);
            end

            m_kind = kind;
            m_idx  = (w >= 0) ? w : 0;
            m_we   = (w >= 0) ? host_we_i[w] : 1'b0;
            m_data = (kind == 1) ? smem_rd(int'(a >> 2)) : 32'd0;
            if (w >= 0) begin
                grant_q.push_back(w);
                m_ptr = (w + 1) % NH;
            end
            if (kind == 2 && host_we_i[w]) begin
                nxt    = (32'(m_gpio) & ~lane_mask(host_be_i[w]))
                       | (host_wdata_i[w] & lane_mask(host_be_i[w]));
                m_gpio = nxt[GW-1:0];
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_all();
        host_req_i   = '0;
        host_we_i    = '0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        host_be_i    = '0;
    endtask

    task automatic drive(input int h, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        host_req_i[h]   = 1'b1;
        host_we_i[h]    = we;
        host_addr_i[h]  = addr;
        host_wdata_i[h] = wdata;
        host_be_i[h]    = be;
    endtask

    task automatic do_reset();
        rst_sys_n = 1'b0;
        tick();
        tick();
        rst_sys_n = 1'b1;
        tick();
    endtask

    int exp37[4];
    int exp35[6];

    initial begin
        idle_all();
        mem_rdata_i = '0;
        smem[32]    = 32'hDEAD_BEEF;   // byte address 0x80
`ifdef SRAM_ARB_RR_EN
        exp37 = '{0, 1, 2, 0};
        exp35 = '{0, 1, 0, 1, 0, 1};
`else
        exp37 = '{0, 0, 0, 0};
        exp35 = '{0, 0, 0, 0, 0, 0};
`endif
        repeat (3) tick();
        chk("reset_gpio", 32'(gpio_o), 32'd0);
        chk("reset_rvalid", 32'(host_rvalid_o), 32'd0);
        rst_sys_n = 1'b1;
        tick();
        chk("first_cycle_no_rvalid", 32'(host_rvalid_o), 32'd0);

        // SRAM read from host 0
        drive(0, 1'b0, 32'h0000_0080, 32'd0, 4'hF);
        #1 chk("sram_rd_gnt", 32'(host_gnt_o), 32'b001);
        tick();
        idle_all();
        #1;
        chk("sram_rd_rvalid", 32'(host_rvalid_o), 32'b001);
        chk("sram_rd_rdata", host_rdata_o[0], 32'hDEAD_BEEF);
        chk("sram_rd_err", 32'(host_err_o), 32'd0);
        chk("idle_gnt", 32'(host_gnt_o), 32'd0);

        // GPIO write then readback from host 1
        drive(1, 1'b1, GPIO_ADDR, 32'h0000_00A5, 4'b0001);
        #1 chk("gpio_wr_gnt", 32'(host_gnt_o), 32'b010);
        tick();
        idle_all();
        #1 chk("gpio_wr_value", 32'(gpio_o), 32'h0000_00A5);
        drive(1, 1'b0, GPIO_ADDR, 32'd0, 4'hF);
        tick();
        idle_all();
        #1 chk("gpio_readback", host_rdata_o[1], 32'h0000_00A5);

        // Read granted one cycle before a GPIO write sees the old value
        drive(0, 1'b0, GPIO_ADDR, 32'd0, 4'hF);
        tick();
        idle_all();
        drive(1, 1'b1, GPIO_ADDR, 32'h0000_003C, 4'b0001);
        #1 chk("gpio_prewrite_rdata", host_rdata_o[0], 32'h0000_00A5);
        tick();
        idle_all();
        #1 chk("gpio_after_write", 32'(gpio_o), 32'h0000_003C);

        // Lanes beyond the register width are ignored
        drive(2, 1'b1, GPIO_ADDR + 32'd1, 32'hFFFF_FF00, 4'b1110);
        tick();
        idle_all();
        #1 chk("gpio_high_lanes_ignored", 32'(gpio_o), 32'h0000_003C);

        // SRAM write and read back through another host
        drive(2, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0110);
        tick();
        idle_all();
        drive(0, 1'b0, 32'h0000_0100, 32'd0, 4'hF);
        tick();
        idle_all();
        #1 chk("sram_partial_write", host_rdata_o[0], 32'h0034_5600);

        // Unmapped address
        mem_req_seen = 1'b0;
        drive(1, 1'b0, 32'h4000_0000, 32'd0, 4'hF);
        tick();
        idle_all();
        #1;
        chk("unmapped_rvalid", 32'(host_rvalid_o), 32'b010);
        chk("unmapped_err", 32'(host_err_o), 32'b010);
        chk("unmapped_rdata", host_rdata_o[1], 32'd0);
        chk("unmapped_no_mem_req", 32'(mem_req_seen), 32'd0);

        // Reset the cycle after a grant discards the response
        drive(1, 1'b1, GPIO_ADDR, 32'h0000_0077, 4'b0001);
        tick();
        idle_all();
        drive(0, 1'b0, 32'h0000_0080, 32'd0, 4'hF);
        tick();
        idle_all();
        rst_sys_n = 1'b0;
        #1;
        chk("reset_mid_rvalid", 32'(host_rvalid_o), 32'd0);
        chk("reset_mid_gpio", 32'(gpio_o), 32'd0);
        tick();
        tick();
        rst_sys_n = 1'b1;
        tick();
        chk("release_no_rvalid", 32'(host_rvalid_o), 32'd0);
        chk("release_gpio", 32'(gpio_o), 32'd0);

        // Three hosts requesting continuously
        grant_q.delete();
        drive(0, 1'b0, 32'h0000_0080, 32'd0, 4'hF);
        drive(1, 1'b0, 32'h0000_0084, 32'd0, 4'hF);
        drive(2, 1'b0, 32'h0000_0088, 32'd0, 4'hF);
        repeat (4) tick();
        idle_all();
        chk("three_host_count", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
            chk($sformatf("three_host_grant%0d", i), 32'(grant_q[i]), 32'(exp37[i]));
        end

        // Two hosts requesting continuously after a fresh reset
        do_reset();
        grant_q.delete();
        drive(0, 1'b0, 32'h0000_0080, 32'd0, 4'hF);
        drive(1, 1'b0, 32'h0000_0084, 32'd0, 4'hF);
        repeat (6) tick();
        idle_all();
        chk("two_host_count", 32'(grant_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            chk($sformatf("two_host_grant%0d", i), 32'(grant_q[i]), 32'(exp35[i]));
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_host_arbiter.md
SRAM_HOST_ARBITER -- requirements
Module: sram_host_arbiter

Interface
REQ-001 SHALL have parameter NumHosts, default 2: number of host ports (1..8); index 0 = instruction host.
REQ-002 SHALL have parameter MemStart, default 32'h0000_0000: SRAM base address.
REQ-003 SHALL have parameter MemSize, default 65536: SRAM bytes, power of two.
REQ-004 SHALL have parameter GpioAddr, default 32'h8000_0000: word address of output register.
REQ-005 SHALL have parameter GpioWidth, default 8: output register width (1..32).
REQ-006 SHALL have port clk_sys  in  1  system clock, rising edge.
REQ-007 SHALL have port rst_sys_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports host_req_i / host_we_i  in  NumHosts  per-host request, write enable.
REQ-009 SHALL have ports host_addr_i / host_wdata_i  in  NumHosts x 32  byte address, write data.
REQ-010 SHALL have port host_be_i  in  NumHosts x 4  byte enables.
REQ-011 SHALL have port host_gnt_o  out  NumHosts  combinational grant.
REQ-012 SHALL have ports host_rvalid_o / host_err_o  out  NumHosts  response valid, error.
REQ-013 SHALL have port host_rdata_o  out  NumHosts x 32  response data (shared bus, qualified by rvalid).
REQ-014 SHALL have ports mem_req_o, mem_we_o (1), mem_be_o (4), mem_addr_o (32), mem_wdata_o (32)  out  SRAM request.
REQ-015 SHALL have port mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o.
REQ-016 SHALL have port gpio_o  out  GpioWidth  registered output.

Function
REQ-017 SHALL grant at most one host per cycle; gnt asserted in the same cycle as the winning req.
REQ-018 SHALL decode the granted address: SRAM if (addr & ~(MemSize-1)) == MemStart; GPIO if addr[31:2] == GpioAddr[31:2]; else error.
REQ-019 SHALL assert mem_req_o only for a granted SRAM access; mem_* outputs are 0 otherwise.
REQ-020 SHALL assert rvalid to the granted host exactly one cycle after gnt, for all targets, reads and writes.
REQ-021 SHALL return mem_rdata_i for SRAM, zero-extended gpio register for GPIO reads, 0 with err=1 for unmapped addresses.
REQ-022 SHALL update GPIO bytes whose be bit is set on a granted GPIO write; bits >= GpioWidth are ignored.
REQ-023 SHALL accept back-to-back grants every cycle; response-owner register (host index + target select) captured at gnt.
REQ-024 SHALL not grant a host whose req is deasserted; a request withdrawn before gnt is dropped without response.
REQ-025 SHALL ensure simultaneous GPIO write and response in the same cycle return the pre-write value for a read granted the previous cycle.

Reset
REQ-026 SHALL, while rst_sys_n low, drive gpio_o=0, host_rvalid_o=0, host_err_o=0, owner register=0, round-robin pointer=0.
REQ-027 SHALL discard any response pending at reset assertion; no rvalid in the first cycle after release.

Configuration
REQ-028 SHALL, with SRAM_ARB_RR_EN defined, arbitrate round-robin: pointer moves to winner+1 (mod NumHosts) after each grant.
REQ-029 SHALL, without SRAM_ARB_RR_EN, use fixed priority, lowest index wins (instruction host first).

Structure
REQ-030 SHALL place in package sram_arb_pkg: target-select enum {TGT_NONE, TGT_MEM, TGT_GPIO, TGT_ERR}, MaxHosts=8 constant.
REQ-031 SHALL isolate grant logic in sub-module sram_arb_rr (request vector in, one-hot grant out, pointer state inside).

Verification
REQ-032 SHALL cover: host0 read 0x0000_0080 after SRAM preload 0xDEADBEEF -> gnt0 cycle N, rvalid0 cycle N+1, rdata 0xDEADBEEF, err 0.
REQ-033 SHALL cover: host1 write be=4'b0001 data 0x0000_00A5 to 0x8000_0000 -> gpio_o=8'hA5 next cycle; readback returns 0x0000_00A5.
REQ-034 SHALL cover: host1 read 0x4000_0000 -> rvalid1 err=1 rdata 0, mem_req_o never asserted.
REQ-035 SHALL cover: both hosts requesting continuously 6 cycles -> RR: grants 0,1,0,1,0,1; fixed: six grants to host0, none to host1.
REQ-036 SHALL cover: rst_sys_n asserted the cycle after gnt -> no rvalid, gpio_o=0, pointer=0 after release.
REQ-037 SHALL cover: NumHosts=3, all requesting, RR -> grants 0,1,2,0 with rvalid on matching host each next cycle.
